// File: rtl/sram_frame_loader_if.sv
// Handshake and data bus for the SRAM frame loader.
// master drives commands and cfg data; slave is the loader.
interface sram_frame_loader_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int ADDRW = $clog2(DEPTH)
);
  logic                   io_start;
  logic                   io_mode;
  logic [ADDRW-1:0]       io_startAddr;
  logic [ADDRW:0]         io_frameCount;
  logic                   io_cfgValid;
  logic                   io_cfgReady;
  logic [WIDTH-1:0]       io_cfgData;
  logic                   io_rdValid;
  logic                   io_rdReady;
  logic [WIDTH-1:0]       io_rdData;
  logic [WIDTH*DEPTH-1:0] io_progBits;
  logic [ADDRW-1:0]       io_frameAddr;
  logic                   io_busy;
  logic                   io_done;
  logic                   io_error;

  modport master (
    output io_start, io_mode, io_startAddr, io_frameCount,
    output io_cfgValid, io_cfgData, io_rdReady,
    input  io_cfgReady, io_rdValid, io_rdData, io_progBits,
    input  io_frameAddr, io_busy, io_done, io_error
  );

  modport slave (
    input  io_start, io_mode, io_startAddr, io_frameCount,
    input  io_cfgValid, io_cfgData, io_rdReady,
    output io_cfgReady, io_rdValid, io_rdData, io_progBits,
    output io_frameAddr, io_busy, io_done, io_error
  );
endinterface

// File: rtl/sram_frame_loader.sv
// Loads configuration frames into a register array with a multi-cycle write hold, and reads them back.
// Writes take WR_CYCLES cycles each; cfg is stalled via io_cfgReady, readback waits on io_rdReady.
module sram_frame_loader #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int WR_CYCLES = 2,
  parameter int ADDRW     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  sram_frame_loader_if.slave   bus
);

  localparam int WCW = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, RDBK, DONE, ERR} state_t;

  state_t           state_q, state_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic [ADDRW:0]   rem_q, rem_d;
  logic [WIDTH-1:0] wbuf_q, wbuf_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             we;
  logic             cfg_ready;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic             done;
  logic             error;
  logic [ADDRW+1:0] span;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      wbuf_q  <= '0;
      wcnt_q  <= '0;
      for (int f = 0; f < DEPTH; f++) mem_q[f] <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      wbuf_q  <= wbuf_d;
      wcnt_q  <= wcnt_d;
      if (we) mem_q[addr_q] <= wbuf_q;
    end
  end

  // Range check is done one bit wider than the count so startAddr+count cannot overflow.
  assign span = {2'b00, bus.io_startAddr} + {1'b0, bus.io_frameCount};

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    wbuf_d    = wbuf_q;
    wcnt_d    = wcnt_q;
    we        = 1'b0;
    cfg_ready = 1'b0;
    rd_valid  = 1'b0;
    rd_data   = '0;
    done      = 1'b0;
    error     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.io_start) begin
          addr_d = bus.io_startAddr;
          rem_d  = bus.io_frameCount;
          if (span > (ADDRW+2)'(DEPTH))        state_d = ERR;
          else if (bus.io_frameCount == '0)    state_d = DONE;
          else if (!bus.io_mode)               state_d = LOAD;
          else                                 state_d = RDBK;
        end
      end
      LOAD: begin
        cfg_ready = 1'b1;
        if (bus.io_cfgValid) begin
          wbuf_d  = bus.io_cfgData;
          wcnt_d  = WCW'(WR_CYCLES - 1);
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - WCW'(1);
        end else begin
          we      = 1'b1;
          addr_d  = addr_q + ADDRW'(1);
          rem_d   = rem_q - (ADDRW+1)'(1);
          state_d = (rem_q == (ADDRW+1)'(1)) ? DONE : LOAD;
        end
      end
      RDBK: begin
        rd_valid = 1'b1;
        rd_data  = mem_q[addr_q];
        if (bus.io_rdReady) begin
          addr_d = addr_q + ADDRW'(1);
          rem_d  = rem_q - (ADDRW+1)'(1);
          if (rem_q == (ADDRW+1)'(1)) state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        error   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.io_cfgReady  = cfg_ready;
  assign bus.io_rdValid   = rd_valid;
  assign bus.io_rdData    = rd_data;
  assign bus.io_frameAddr = addr_q;
  assign bus.io_busy      = (state_q != IDLE);
  assign bus.io_done      = done;
  assign bus.io_error     = error;

  for (genvar g = 0; g < DEPTH; g++) begin : g_prog
    assign bus.io_progBits[g*WIDTH +: WIDTH] = mem_q[g];
  end

endmodule

// File: tb/tb_sram_frame_loader.sv
// Directed, table-driven bench for sram_frame_loader (WIDTH=8, DEPTH=16, WR_CYCLES=2).
// Each table row is one clock cycle: inputs driven after negedge, outputs compared before the next posedge.
module tb_sram_frame_loader;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sram_frame_loader_if #(.WIDTH(8), .DEPTH(16), .ADDRW(4)) bus ();

  sram_frame_loader #(.WIDTH(8), .DEPTH(16), .WR_CYCLES(2), .ADDRW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic       start;
    logic       mode;
    logic [3:0] sa;
    logic [4:0] cnt;
    logic       cv;
    logic [7:0] cd;
    logic       rr;
    logic       e_crdy;
    logic       e_rv;
    logic [7:0] e_rd;
    logic       e_busy;
    logic       e_done;
    logic       e_err;
    logic [3:0] e_fa;
  } vec_t;

  vec_t vecs[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [127:0] exp_pb;

  function automatic vec_t mk(input int start, input int mode, input int sa, input int cnt,
                              input int cv, input int cd, input int rr,
                              input int crdy, input int rv, input int rd, input int busy,
                              input int dn, input int er, input int fa);
    vec_t v;
    v.start = 1'(start); v.mode = 1'(mode); v.sa = 4'(sa); v.cnt = 5'(cnt);
    v.cv = 1'(cv); v.cd = 8'(cd); v.rr = 1'(rr);
    v.e_crdy = 1'(crdy); v.e_rv = 1'(rv); v.e_rd = 8'(rd); v.e_busy = 1'(busy);
    v.e_done = 1'(dn); v.e_err = 1'(er); v.e_fa = 4'(fa);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.io_start = 1'b0; bus.io_mode = 1'b0; bus.io_startAddr = '0; bus.io_frameCount = '0;
    bus.io_cfgValid = 1'b0; bus.io_cfgData = '0; bus.io_rdReady = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag, input logic [3:0] fa);
    chk({tag, " cfgReady"}, 128'(bus.io_cfgReady), 128'(0));
    chk({tag, " rdValid"},  128'(bus.io_rdValid),  128'(0));
    chk({tag, " rdData"},   128'(bus.io_rdData),   128'(0));
    chk({tag, " busy"},     128'(bus.io_busy),     128'(0));
    chk({tag, " done"},     128'(bus.io_done),     128'(0));
    chk({tag, " error"},    128'(bus.io_error),    128'(0));
    chk({tag, " frameAddr"},128'(bus.io_frameAddr),128'(fa));
  endtask

  initial begin
    drive_idle();

    // Single write: frame 3 <= A5, valid held throughout.
    vecs.push_back(mk(1,0, 3,1, 1,8'hA5,0,  0,0,0,   0,0,0, 0));
    vecs.push_back(mk(0,0, 0,0, 1,8'hA5,0,  1,0,0,   1,0,0, 3));
    vecs.push_back(mk(0,0, 0,0, 1,8'hA5,0,  0,0,0,   1,0,0, 3));
    vecs.push_back(mk(0,0, 0,0, 1,8'hA5,0,  0,0,0,   1,0,0, 3));
    vecs.push_back(mk(0,0, 0,0, 1,8'hA5,0,  0,0,0,   1,1,0, 4));
    vecs.push_back(mk(0,0, 0,0, 0,0,0,      0,0,0,   0,0,0, 4));
    // Burst 14..15 with a 3-cycle stall; start pulses while busy must be ignored.
    vecs.push_back(mk(1,0,14,2, 1,8'h11,0,  0,0,0,   0,0,0, 4));
    vecs.push_back(mk(0,0, 0,0, 1,8'h11,0,  1,0,0,   1,0,0,14));
    vecs.push_back(mk(0,0, 0,0, 0,0,0,      0,0,0,   1,0,0,14));
    vecs.push_back(mk(0,0, 0,0, 0,0,0,      0,0,0,   1,0,0,14));
    vecs.push_back(mk(0,0, 0,0, 0,0,0,      1,0,0,   1,0,0,15));
    vecs.push_back(mk(0,0, 0,0, 0,0,0,      1,0,0,   1,0,0,15));
    vecs.push_back(mk(1,0, 0,5, 0,0,0,      1,0,0,   1,0,0,15));
    vecs.push_back(mk(0,0, 0,0, 1,8'h22,0,  1,0,0,   1,0,0,15));
    vecs.push_back(mk(0,0, 0,0, 0,0,0,      0,0,0,   1,0,0,15));
    vecs.push_back(mk(1,0, 0,5, 0,0,0,      0,0,0,   1,0,0,15));
    vecs.push_back(mk(0,0, 0,0, 0,0,0,      0,0,0,   1,1,0, 0));
    vecs.push_back(mk(0,0, 0,0, 0,0,0,      0,0,0,   0,0,0, 0));
    // Readback 14..15 with rdReady low for 2 cycles.
    vecs.push_back(mk(1,1,14,2, 0,0,0,      0,0,0,   0,0,0, 0));
    vecs.push_back(mk(0,0, 0,0, 0,0,0,      0,1,8'h11,1,0,0,14));
    vecs.push_back(mk(0,0, 0,0, 0,0,0,      0,1,8'h11,1,0,0,14));
    vecs.push_back(mk(0,0, 0,0, 0,0,1,      0,1,8'h11,1,0,0,14));
    vecs.push_back(mk(0,0, 0,0, 0,0,1,      0,1,8'h22,1,0,0,15));
    vecs.push_back(mk(0,0, 0,0, 0,0,0,      0,0,0,   1,1,0, 0));
    vecs.push_back(mk(0,0, 0,0, 0,0,0,      0,0,0,   0,0,0, 0));
    // Range error 15+2 > 16.
    vecs.push_back(mk(1,0,15,2, 0,0,0,      0,0,0,   0,0,0, 0));
    vecs.push_back(mk(0,0, 0,0, 0,0,0,      0,0,0,   1,0,1,15));
    vecs.push_back(mk(0,0, 0,0, 0,0,0,      0,0,0,   0,0,0,15));
    // Boundary: 15+1 = 16 is legal, readback of last frame.
    vecs.push_back(mk(1,1,15,1, 0,0,1,      0,0,0,   0,0,0,15));
    vecs.push_back(mk(0,0, 0,0, 0,0,1,      0,1,8'h22,1,0,0,15));
    vecs.push_back(mk(0,0, 0,0, 0,0,0,      0,0,0,   1,1,0, 0));
    vecs.push_back(mk(0,0, 0,0, 0,0,0,      0,0,0,   0,0,0, 0));
    // Zero count: done without any write.
    vecs.push_back(mk(1,0, 5,0, 0,0,0,      0,0,0,   0,0,0, 0));
    vecs.push_back(mk(0,0, 0,0, 0,0,0,      0,0,0,   1,1,0, 5));
    vecs.push_back(mk(0,0, 0,0, 0,0,0,      0,0,0,   0,0,0, 5));

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    chk_idle_outputs("reset", 4'd0);
    chk("reset progBits", bus.io_progBits, 128'(0));
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      bus.io_start      = vecs[i].start;
      bus.io_mode       = vecs[i].mode;
      bus.io_startAddr  = vecs[i].sa;
      bus.io_frameCount = vecs[i].cnt;
      bus.io_cfgValid   = vecs[i].cv;
      bus.io_cfgData    = vecs[i].cd;
      bus.io_rdReady    = vecs[i].rr;
      #1;
      chk($sformatf("row%0d cfgReady", i),  128'(bus.io_cfgReady),  128'(vecs[i].e_crdy));
      chk($sformatf("row%0d rdValid", i),   128'(bus.io_rdValid),   128'(vecs[i].e_rv));
      chk($sformatf("row%0d rdData", i),    128'(bus.io_rdData),    128'(vecs[i].e_rd));
      chk($sformatf("row%0d busy", i),      128'(bus.io_busy),      128'(vecs[i].e_busy));
      chk($sformatf("row%0d done", i),      128'(bus.io_done),      128'(vecs[i].e_done));
      chk($sformatf("row%0d error", i),     128'(bus.io_error),     128'(vecs[i].e_err));
      chk($sformatf("row%0d frameAddr", i), 128'(bus.io_frameAddr), 128'(vecs[i].e_fa));
      if (i == 5) begin
        exp_pb = '0;
        exp_pb[3*8 +: 8] = 8'hA5;
        chk("single write progBits", bus.io_progBits, exp_pb);
      end
    end

    @(negedge clk);
    drive_idle();
    #1;
    exp_pb = '0;
    exp_pb[3*8 +: 8]  = 8'hA5;
    exp_pb[14*8 +: 8] = 8'h11;
    exp_pb[15*8 +: 8] = 8'h22;
    chk("final progBits", bus.io_progBits, exp_pb);

    // Reset in the second WRITE cycle must clear the array and abort.
    @(negedge clk);
    bus.io_start = 1'b1; bus.io_mode = 1'b0; bus.io_startAddr = 4'd7; bus.io_frameCount = 5'd1;
    bus.io_cfgValid = 1'b1; bus.io_cfgData = 8'h5C;
    @(negedge clk);
    bus.io_start = 1'b0;
    @(negedge clk);
    #1;
    chk("midwrite busy before reset", 128'(bus.io_busy), 128'(1));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bus.io_cfgValid = 1'b0;
    #1;
    chk_idle_outputs("midwrite reset", 4'd0);
    chk("midwrite reset progBits", bus.io_progBits, 128'(0));
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("after reset release busy", 128'(bus.io_busy), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_frame_loader.md
SRAM_FRAME_LOADER -- requirements
Module: sram_frame_loader

Interface
REQ-001 The module SHALL take these parameters (name, default, meaning):
- WIDTH, 8, configuration bits per frame.
- DEPTH, 16, number of frames, at least 2.
- WR_CYCLES, 2, clock cycles a frame write is held, at least 1.
- ADDRW, clog2(DEPTH), frame address width.

REQ-002 The module SHALL have one clock and a synchronous, active-low reset. Ports are listed as name, direction, width, meaning:
- clk, in, 1, clock.
- reset, in, 1, synchronous active-low reset.
- io_start, in, 1, begin an operation; sampled only in IDLE.
- io_mode, in, 1, 0 = write frames, 1 = read back frames.
- io_startAddr, in, ADDRW, first frame.
- io_frameCount, in, ADDRW+1, number of frames.
- io_cfgValid, in, 1, write data valid.
- io_cfgReady, out, 1, write data accepted.
- io_cfgData, in, WIDTH, frame to write.
- io_rdValid, out, 1, readback data valid.
- io_rdReady, in, 1, readback consumer ready.
- io_rdData, out, WIDTH, readback frame.
- io_progBits, out, WIDTH*DEPTH, all stored bits; frame f occupies bits [f*WIDTH +: WIDTH].
- io_frameAddr, out, ADDRW, current frame pointer.
- io_busy, out, 1, high in any state other than IDLE.
- io_done, out, 1, one-cycle completion pulse.
- io_error, out, 1, one-cycle range-error pulse.

Function
REQ-003 The state machine SHALL have exactly these states: IDLE, LOAD, WRITE, RDBK, DONE, ERR.

REQ-004 In IDLE with io_start=1, the block SHALL latch io_startAddr into addr and io_frameCount into remaining. It SHALL then go to the first matching state:
- ERR, if io_startAddr + io_frameCount > DEPTH, computed in ADDRW+2 bits.
- DONE, if io_frameCount = 0.
- LOAD, if io_mode = 0.
- RDBK, if io_mode = 1.

REQ-005 io_start SHALL be ignored in every state other than IDLE.

REQ-006 io_cfgReady SHALL be 1 only in LOAD. A handshake (io_cfgValid & io_cfgReady) SHALL latch io_cfgData into wbuf, load wcnt = WR_CYCLES-1, and move to WRITE on the next edge.

REQ-007 In LOAD with io_cfgValid = 0, the block SHALL stay in LOAD indefinitely with no side effects.

REQ-008 In WRITE, wcnt SHALL decrement by one each cycle while nonzero. On the edge where wcnt = 0, the block SHALL:
- write wbuf into frame addr of the array;
- set addr to addr+1 and remaining to remaining-1;
- go to DONE if the new remaining = 0, otherwise to LOAD.

REQ-009 A frame write SHALL therefore take exactly WR_CYCLES cycles in WRITE. The new frame SHALL be visible on io_progBits in the cycle after WRITE exits.

REQ-010 io_progBits SHALL change only as described in REQ-008 and at reset. Frames outside the addressed range SHALL never change.

REQ-011 In RDBK, io_rdValid SHALL be 1 and io_rdData SHALL equal frame addr, combinationally from the array.

REQ-012 A readback handshake (io_rdValid & io_rdReady) SHALL set addr to addr+1 and remaining to remaining-1. The block SHALL go to DONE when the new remaining = 0.

REQ-013 io_rdData SHALL hold stable while io_rdValid = 1 and io_rdReady = 0.

REQ-014 Outside RDBK, io_rdValid SHALL be 0 and io_rdData SHALL be 0.

REQ-015 DONE SHALL assert io_done for exactly one cycle, then return to IDLE.

REQ-016 ERR SHALL assert io_error for exactly one cycle, leave the array unchanged, then return to IDLE. io_done SHALL NOT be asserted on an error.

REQ-017 io_frameAddr SHALL always reflect addr.

REQ-018 addr SHALL never exceed DEPTH-1 while accessing the array. The final increment, to startAddr+count, may wrap and SHALL have no effect on the array.

REQ-019 A frame at address DEPTH-1 SHALL be writable and readable. A request with startAddr = DEPTH-1 and count = 1 is legal.

Reset
REQ-020 While reset = 0 at a clk edge, the block SHALL set:
- state to IDLE;
- every array bit to 0, so io_progBits = 0;
- addr, remaining, wbuf and wcnt to 0.

REQ-021 The outputs SHALL be 0 during and after reset: io_cfgReady, io_rdValid, io_rdData, io_busy, io_done, io_error and io_frameAddr.

REQ-022 Reset asserted mid-operation, including in the middle of a WRITE, SHALL abort the operation. No partial frame SHALL remain, because the array is cleared.

Verification
REQ-023 The bench SHALL cover at least these directed scenarios, with defaults WIDTH=8, DEPTH=16, WR_CYCLES=2:
- Single write: start, mode=0, addr=3, count=1; send 0xA5 with valid held -> cfgReady for 1 cycle; 2 cycles in WRITE; frame 3 = 0xA5; done pulses; all other frames remain 0.
- Burst with stalls: addr=14, count=2, data 0x11 then 0x22, with cfgValid dropped for 3 cycles between them -> frames 14 and 15 written; 4 WRITE cycles total; done once.
- Readback with backpressure: after the burst, start mode=1, addr=14, count=2, rdReady low for 2 cycles -> rdData holds 0x11, then shows 0x22; done pulses after the second handshake.
- Range errors: addr=15, count=2 -> error pulses for 1 cycle, no done, array unchanged. count=0 -> done pulses with no write.
- Mid-write reset: reset asserted during the second WRITE cycle -> next cycle io_progBits = 0, state IDLE, busy = 0.
- Start ignored: io_start pulsed while busy -> no effect on addr or remaining.
